// File: rtl/coh_bus_pkg.sv
// coh_bus_pkg: definitions shared by the MESI CPU, cache and bus responder blocks.
//   - bus_op / mem_op encodings carried in the upper bits of a bus message
//   - message width and field positions as functions of the tag and data widths
//   - responder FSM state enum
// Message layout (MSB first): {bus_op[1:0], mem_op[1:0], tag[TAG_W-1:0], data[DATA_W-1:0]}
package coh_bus_pkg;

  localparam logic [1:0] BUS_NONE    = 2'b00;
  localparam logic [1:0] BUS_RD_MISS = 2'b01;
  localparam logic [1:0] BUS_WR_MISS = 2'b10;
  localparam logic [1:0] BUS_INVAL   = 2'b11;

  localparam logic [1:0] MEM_NONE       = 2'b00;
  localparam logic [1:0] MEM_READ       = 2'b01;
  localparam logic [1:0] MEM_WRITE_BACK = 2'b10;
  localparam logic [1:0] MEM_RSVD       = 2'b11;

  function automatic int unsigned msg_w(input int unsigned tag_w, input int unsigned data_w);
    return 4 + tag_w + data_w;
  endfunction

  function automatic int unsigned bus_op_lsb(input int unsigned tag_w, input int unsigned data_w);
    return 2 + tag_w + data_w;
  endfunction

  function automatic int unsigned mem_op_lsb(input int unsigned tag_w, input int unsigned data_w);
    return tag_w + data_w;
  endfunction

  function automatic int unsigned tag_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    BCAST,
    SNOOP,
    MEM,
    RESP
  } state_t;

endpackage

// File: rtl/bus_memory.sv
// bus_memory: main-memory array behind the snoop bus responder.
//   clock  : rising-edge clock
//   clear  : synchronous active-high reset; loads mem[a] = a
//   wr_en  : write wdata to mem[addr] at the next rising edge
//   addr   : word address
//   wdata  : write data
//   rdata  : registered read of mem[addr] (value before any same-edge write)
module bus_memory #(
  parameter int unsigned TAG_W  = 3,
  parameter int unsigned DATA_W = 3
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [TAG_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** TAG_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int unsigned a = 0; a < DEPTH; a++) begin
        mem[a[TAG_W-1:0]] <= DATA_W'(a);
      end
      rdata <= '0;
    end else begin
      if (wr_en) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/snoop_bus_responder.sv
// snoop_bus_responder: shared-bus / main-memory end of the MESI coherence interface.
// Accepts one request, broadcasts it to the snoopers, ORs their shared lines over
// a fixed window, performs the memory read or write-back, then pulses a response.
//   clock       : rising-edge clock
//   clear       : synchronous active-high reset, aborts any in-flight request
//   req_valid   : request present on req_msg
//   req_ready   : high only in IDLE
//   req_msg     : {bus_op, mem_op, tag, data}
//   shared_in   : wired-OR of the snooping caches' shared_out
//   bus_in      : latched copy of the accepted message (held until next accept)
//   bus_valid   : one-cycle broadcast strobe
//   resp_valid  : one-cycle completion pulse
//   resp_data   : memory read data, 0 when no read was performed (held)
//   resp_shared : a snooper reported shared during the window (held)
module snoop_bus_responder
  import coh_bus_pkg::*;
#(
  parameter int unsigned TAG_W        = 3,
  parameter int unsigned DATA_W       = 3,
  parameter int unsigned SNOOP_CYCLES = 2,
  parameter int unsigned MEM_LATENCY  = 2
) (
  input  logic                                   clock,
  input  logic                                   clear,
  input  logic                                   req_valid,
  output logic                                   req_ready,
  input  logic [coh_bus_pkg::msg_w(TAG_W, DATA_W)-1:0] req_msg,
  input  logic                                   shared_in,
  output logic [coh_bus_pkg::msg_w(TAG_W, DATA_W)-1:0] bus_in,
  output logic                                   bus_valid,
  output logic                                   resp_valid,
  output logic [DATA_W-1:0]                      resp_data,
  output logic                                   resp_shared
);

  localparam int unsigned BOP_LSB = bus_op_lsb(TAG_W, DATA_W);
  localparam int unsigned MOP_LSB = mem_op_lsb(TAG_W, DATA_W);
  localparam int unsigned TAG_LSB = tag_lsb(DATA_W);
  localparam int unsigned MAX_CNT = (SNOOP_CYCLES > MEM_LATENCY) ? SNOOP_CYCLES : MEM_LATENCY;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] SNOOP_LAST = CNT_W'(SNOOP_CYCLES - 1);
  localparam logic [CNT_W-1:0] MEM_LAST   = CNT_W'(MEM_LATENCY - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              shared_acc;

  logic [1:0]        bop;
  logic [1:0]        mop;
  logic [TAG_W-1:0]  tag;
  logic [DATA_W-1:0] data;
  logic              has_mem;
  logic              is_read;
  logic              shared_next;
  logic              wr_en;
  logic [DATA_W-1:0] rdata;

  always_comb begin
    bop         = bus_in[BOP_LSB +: 2];
    mop         = bus_in[MOP_LSB +: 2];
    tag         = bus_in[TAG_LSB +: TAG_W];
    data        = bus_in[DATA_W-1:0];
    has_mem     = (mop == MEM_READ) || (mop == MEM_WRITE_BACK);
    is_read     = (mop == MEM_READ);
    shared_next = shared_acc | shared_in;
    wr_en       = (state == MEM) && (cnt == MEM_LAST) && (mop == MEM_WRITE_BACK);
  end

  // The array's read register tracks mem[tag] every cycle, and tag is stable from
  // BCAST onward, so rdata is already valid in the last MEM cycle and resp_data
  // can be loaded straight from it on the edge that enters RESP.
  bus_memory #(
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clock (clock),
    .clear (clear),
    .wr_en (wr_en),
    .addr  (tag),
    .wdata (data),
    .rdata (rdata)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= IDLE;
      cnt         <= '0;
      shared_acc  <= 1'b0;
      req_ready   <= 1'b1;
      bus_in      <= '0;
      bus_valid   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_data   <= '0;
      resp_shared <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            bus_in    <= req_msg;
            bus_valid <= 1'b1;
            req_ready <= 1'b0;
            state     <= BCAST;
          end
        end
        BCAST: begin
          bus_valid  <= 1'b0;
          shared_acc <= 1'b0;
          cnt        <= '0;
          if (bop != BUS_NONE) begin
            state <= SNOOP;
          end else if (has_mem) begin
            state <= MEM;
          end else begin
            state       <= RESP;
            resp_valid  <= 1'b1;
            resp_data   <= '0;
            resp_shared <= 1'b0;
          end
        end
        SNOOP: begin
          shared_acc <= shared_next;
          if (cnt == SNOOP_LAST) begin
            cnt <= '0;
            if (has_mem) begin
              state <= MEM;
            end else begin
              // Final sample joins the flag on the same edge it is taken.
              state       <= RESP;
              resp_valid  <= 1'b1;
              resp_data   <= '0;
              resp_shared <= shared_next;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        MEM: begin
          if (cnt == MEM_LAST) begin
            cnt         <= '0;
            state       <= RESP;
            resp_valid  <= 1'b1;
            resp_data   <= is_read ? rdata : '0;
            resp_shared <= shared_acc;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_bus_responder.sv
// tb_snoop_bus_responder: directed-vector bench for snoop_bus_responder with
// default parameters (10-bit messages). Inputs change 1 ns after each rising
// edge; outputs are sampled at the same point.
module tb_snoop_bus_responder;

  logic       clock;
  logic       clear;
  logic       req_valid;
  logic       req_ready;
  logic [9:0] req_msg;
  logic       shared_in;
  logic [9:0] bus_in;
  logic       bus_valid;
  logic       resp_valid;
  logic [2:0] resp_data;
  logic       resp_shared;

  int checks;
  int failures;

  snoop_bus_responder #(
    .TAG_W        (3),
    .DATA_W       (3),
    .SNOOP_CYCLES (2),
    .MEM_LATENCY  (2)
  ) dut (
    .clock       (clock),
    .clear       (clear),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_msg     (req_msg),
    .shared_in   (shared_in),
    .bus_in      (bus_in),
    .bus_valid   (bus_valid),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_shared (resp_shared)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One complete transaction starting in IDLE. mask[k] drives shared_in during
  // cycle k after the accept edge (cycle 1 = BCAST).
  task automatic run_txn(input string name, input logic [9:0] msg, input logic [31:0] mask,
                         input int exp_lat, input logic [2:0] exp_data, input logic exp_sh);
    int lat;
    check({name, "_ready_pre"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_msg   = msg;
    step();
    req_valid = 1'b0;
    check({name, "_bus_valid"}, 32'(bus_valid), 32'd1);
    check({name, "_bus_in"}, 32'(bus_in), 32'(msg));
    check({name, "_ready_busy"}, 32'(req_ready), 32'd0);
    shared_in = mask[1];
    lat = 0;
    for (int k = 2; k <= 20; k++) begin
      step();
      if (resp_valid) begin
        lat = k;
        break;
      end
      if (k == 2) check({name, "_bus_valid_drop"}, 32'(bus_valid), 32'd0);
      shared_in = mask[k];
    end
    shared_in = 1'b0;
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_resp_data"}, 32'(resp_data), 32'(exp_data));
    check({name, "_resp_shared"}, 32'(resp_shared), 32'(exp_sh));
    check({name, "_ready_at_resp"}, 32'(req_ready), 32'd0);
    step();
    check({name, "_resp_pulse"}, 32'(resp_valid), 32'd0);
    check({name, "_ready_post"}, 32'(req_ready), 32'd1);
    check({name, "_data_hold"}, 32'(resp_data), 32'(exp_data));
  endtask

  initial begin
    int lat;
    checks    = 0;
    failures  = 0;
    clear     = 1'b1;
    req_valid = 1'b0;
    req_msg   = '0;
    shared_in = 1'b0;
    step();
    step();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_bus_valid", 32'(bus_valid), 32'd0);
    check("rst_bus_in", 32'(bus_in), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_resp_shared", 32'(resp_shared), 32'd0);
    clear = 1'b0;
    step();

    // RD_MISS/READ tag 5, no sharers
    run_txn("rd5", 10'b01_01_101_000, 32'h0, 6, 3'd5, 1'b0);
    // RD_MISS/READ tag 2, shared only in first SNOOP cycle
    run_txn("rd2_sh", 10'b01_01_010_000, 32'h4, 6, 3'd2, 1'b1);
    // shared only in the last SNOOP cycle
    run_txn("rd2_last", 10'b01_01_010_000, 32'h8, 6, 3'd2, 1'b1);
    // shared only outside the window (BCAST and MEM cycles)
    run_txn("rd2_out", 10'b01_01_010_000, 32'h32, 6, 3'd2, 1'b0);
    // write-back then read-after-write
    run_txn("wb3", 10'b10_10_011_111, 32'h0, 6, 3'd0, 1'b0);
    run_txn("raw3", 10'b01_01_011_000, 32'h0, 6, 3'd7, 1'b0);
    // INVAL/NONE, shared high throughout
    run_txn("inval1", 10'b11_00_001_000, 32'hFFFF_FFFF, 4, 3'd0, 1'b1);
    run_txn("rd1", 10'b01_01_001_000, 32'h0, 6, 3'd1, 1'b0);
    // NONE/NONE: no snoop window, shared ignored
    run_txn("none", 10'b00_00_010_101, 32'hFFFF_FFFF, 2, 3'd0, 1'b0);

    // req_valid held with message changed mid-transaction
    req_valid = 1'b1;
    req_msg   = 10'b01_00_110_000;
    step();
    check("hold_bus_in_a", 32'(bus_in), 32'(10'b01_00_110_000));
    req_msg = 10'b01_01_111_000;
    lat = 0;
    for (int k = 2; k <= 20; k++) begin
      step();
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
    check("hold_latency_a", 32'(lat), 32'd4);
    check("hold_bus_in_kept", 32'(bus_in), 32'(10'b01_00_110_000));
    step();
    check("hold_ready_idle", 32'(req_ready), 32'd1);
    step();
    check("hold_bus_valid_b", 32'(bus_valid), 32'd1);
    check("hold_bus_in_b", 32'(bus_in), 32'(10'b01_01_111_000));
    req_valid = 1'b0;
    lat = 0;
    for (int k = 2; k <= 20; k++) begin
      step();
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
    check("hold_latency_b", 32'(lat), 32'd6);
    check("hold_data_b", 32'(resp_data), 32'd7);
    step();

    // clear during the last MEM cycle of a write-back to tag 4
    check("abort_ready_pre", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_msg   = 10'b10_10_100_110;
    step();
    req_valid = 1'b0;
    for (int k = 2; k <= 5; k++) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_bus_in", 32'(bus_in), 32'd0);
    run_txn("rd4_after_clr", 10'b01_01_100_000, 32'h0, 6, 3'd4, 1'b0);
    run_txn("rd3_after_clr", 10'b01_01_011_000, 32'h0, 6, 3'd3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
